// File: rtl/memfifo_readout_packer.sv
// rtl/memfifo_readout_packer.sv - pairs memory-FIFO reads into packets and audits the run's packet count
module memfifo_readout_packer #(
    parameter int DATA_WIDTH   = 64,
    parameter int CNT_WIDTH    = 16,
    parameter int FIFO_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memfifo_re,
    input  logic                    last_memfifo_re,
    input  logic [CNT_WIDTH-1:0]    packet_no,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic                    pkt_valid,
    output logic [2*DATA_WIDTH-1:0] pkt_data,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic                    done,
    output logic                    underflow_err,
    output logic                    count_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [FIFO_LATENCY-1:0] slot_vld;
    logic [FIFO_LATENCY-1:0] slot_real;
    logic [DATA_WIDTH-1:0]   lo_word;
    logic [DATA_WIDTH-1:0]   cap_word;
    logic                    half_sel;
    logic [CNT_WIDTH-1:0]    exp_cnt;
    logic [2:0]              drain_cnt;
    logic                    accept;

    assign accept     = memfifo_re && (state == IDLE || state == RUN) && !reset;
    assign fifo_rd_en = accept && !fifo_empty;
    // An underflowed slot still occupies its half so later words stay paired correctly.
    assign cap_word   = slot_real[FIFO_LATENCY-1] ? fifo_rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            slot_vld      <= '0;
            slot_real     <= '0;
            lo_word       <= '0;
            half_sel      <= 1'b0;
            exp_cnt       <= '0;
            drain_cnt     <= '0;
            pkt_valid     <= 1'b0;
            pkt_data      <= '0;
            pkt_cnt       <= '0;
            done          <= 1'b0;
            underflow_err <= 1'b0;
            count_err     <= 1'b0;
        end else begin
            pkt_valid    <= 1'b0;
            done         <= 1'b0;
            slot_vld[0]  <= accept;
            slot_real[0] <= accept && !fifo_empty;
            for (int i = 1; i < FIFO_LATENCY; i++) begin
                slot_vld[i]  <= slot_vld[i-1];
                slot_real[i] <= slot_real[i-1];
            end

            if (slot_vld[FIFO_LATENCY-1]) begin
                half_sel <= !half_sel;
                if (!half_sel) begin
                    lo_word <= cap_word;
                end else begin
                    pkt_data  <= {cap_word, lo_word};
                    pkt_valid <= 1'b1;
                    if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (memfifo_re) begin
                        pkt_cnt       <= '0;
                        half_sel      <= 1'b0;
                        underflow_err <= fifo_empty;
                        count_err     <= 1'b0;
                        exp_cnt       <= packet_no;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (memfifo_re && fifo_empty) underflow_err <= 1'b1;
                    if (last_memfifo_re) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (memfifo_re) count_err <= 1'b1;
                    if (drain_cnt == 3'(FIFO_LATENCY)) state <= DONE;
                    else drain_cnt <= drain_cnt + 3'd1;
                end
                DONE: begin
                    done     <= 1'b1;
                    half_sel <= 1'b0;
                    if (memfifo_re || pkt_cnt != exp_cnt || half_sel) count_err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
